// File: rtl/control_busqueda.sv
// Instruction-fetch sequencer: owns the PC, waits LATENCIA cycles per fetch, hands the word to decode.
// Latency LATENCIA cycles from a stable dir_pc to valida; detener holds the delivered word; salto redirects.
// Build with CHEQUEO_ALINEACION_EN to word-align redirect targets and raise the sticky error_alin flag.
module control_busqueda #(
    parameter int          LATENCIA   = 4,
    parameter logic [31:0] PC_INICIO  = 32'h0000_0000,
    parameter int          ANCHO_CONT = 8
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] dir_pc,
    input  logic [31:0] instruccion_mem,
    input  logic        detener,
    input  logic        salto,
    input  logic [31:0] dir_salto,
    output logic [31:0] instruccion,
    output logic [31:0] pc_inst,
    output logic        valida
`ifdef CHEQUEO_ALINEACION_EN
    ,
    output logic        error_alin
`endif
);

    typedef enum logic {ESPERA, ENTREGA} estado_t;

    localparam logic [ANCHO_CONT-1:0] CONT_FIN = ANCHO_CONT'(LATENCIA - 1);

    estado_t               estado;
    logic [ANCHO_CONT-1:0] cont;
    logic [31:0]           destino;

`ifdef CHEQUEO_ALINEACION_EN
    assign destino = {dir_salto[31:2], 2'b00};
`else
    assign destino = dir_salto;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dir_pc      <= PC_INICIO;
            instruccion <= 32'h0;
            pc_inst     <= 32'h0;
            valida      <= 1'b0;
            cont        <= '0;
            estado      <= ESPERA;
`ifdef CHEQUEO_ALINEACION_EN
            error_alin  <= 1'b0;
`endif
        end else if (salto) begin
            // Redirect wins over delivery: a word accepted in this same cycle is dropped.
            dir_pc <= destino;
            valida <= 1'b0;
            cont   <= '0;
            estado <= ESPERA;
`ifdef CHEQUEO_ALINEACION_EN
            if (dir_salto[1:0] != 2'b00) begin
                error_alin <= 1'b1;
            end
`endif
        end else begin
            case (estado)
                ESPERA: begin
                    if (cont == CONT_FIN) begin
                        instruccion <= instruccion_mem;
                        pc_inst     <= dir_pc;
                        valida      <= 1'b1;
                        cont        <= '0;
                        estado      <= ENTREGA;
                    end else begin
                        cont <= cont + 1'b1;
                    end
                end
                ENTREGA: begin
                    if (!detener) begin
                        dir_pc <= dir_pc + 32'd4;
                        valida <= 1'b0;
                        cont   <= '0;
                        estado <= ESPERA;
                    end
                end
                default: begin
                    estado <= ESPERA;
                    cont   <= '0;
                    valida <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_control_busqueda.sv
// Bench for control_busqueda: cycle table for timing, scoreboard for delivered words, hand sequences for corners.
module tb_control_busqueda;

    logic        clk = 1'b0;
    logic        reset;
    logic        detener, salto;
    logic [31:0] dir_salto;
    logic [31:0] dir_pc, instruccion_mem, instruccion, pc_inst;
    logic        valida;
    logic [31:0] dir_pc1, instruccion_mem1, instruccion1, pc_inst1;
    logic        valida1;
`ifdef CHEQUEO_ALINEACION_EN
    logic        error_alin, error_alin1;
`endif

    int total = 0;
    int bad   = 0;
    logic [31:0] esperados[$];

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        if (a == 32'h0) return 32'h2008_0005;
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    assign instruccion_mem  = mem(dir_pc);
    assign instruccion_mem1 = mem(dir_pc1);

    control_busqueda dut (
        .clk(clk), .reset(reset), .dir_pc(dir_pc), .instruccion_mem(instruccion_mem),
        .detener(detener), .salto(salto), .dir_salto(dir_salto),
        .instruccion(instruccion), .pc_inst(pc_inst), .valida(valida)
`ifdef CHEQUEO_ALINEACION_EN
        , .error_alin(error_alin)
`endif
    );

    control_busqueda #(.LATENCIA(1)) dut1 (
        .clk(clk), .reset(reset), .dir_pc(dir_pc1), .instruccion_mem(instruccion_mem1),
        .detener(detener), .salto(salto), .dir_salto(dir_salto),
        .instruccion(instruccion1), .pc_inst(pc_inst1), .valida(valida1)
`ifdef CHEQUEO_ALINEACION_EN
        , .error_alin(error_alin1)
`endif
    );

    task automatic chk(input string nombre, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at t=%0t", nombre, got, exp, $time);
        end
    endtask

    // Scoreboard: a word is consumed when valida meets !detener with no redirect at the next edge.
    always @(negedge clk) begin
        if (!reset && valida && !detener && !salto) begin
            if (esperados.size() == 0) begin
                chk("sb_unexpected_pc", pc_inst, 32'hxxxx_xxxx);
            end else begin
                logic [31:0] pc_esp;
                pc_esp = esperados.pop_front();
                chk("sb_pc_inst", pc_inst, pc_esp);
                chk("sb_instruccion", instruccion, mem(pc_esp));
            end
        end
    end

    task automatic paso(input logic s, input logic d, input logic [31:0] ds);
        salto = s; detener = d; dir_salto = ds;
        @(posedge clk);
        #1;
        salto = 1'b0; detener = 1'b0;
    endtask

    typedef struct {
        logic        s;
        logic        d;
        logic [31:0] ds;
        logic        push;
        logic [31:0] push_pc;
        logic [31:0] e_dir;
        logic        e_v;
        logic [31:0] e_pci;
    } fila_t;

    function automatic fila_t mk(input logic s, input logic d, input logic [31:0] ds,
                                 input logic push, input logic [31:0] push_pc,
                                 input logic [31:0] e_dir, input logic e_v, input logic [31:0] e_pci);
        fila_t f;
        f.s = s; f.d = d; f.ds = ds; f.push = push; f.push_pc = push_pc;
        f.e_dir = e_dir; f.e_v = e_v; f.e_pci = e_pci;
        return f;
    endfunction

    fila_t tabla[21];
    logic        exp1_v[3];
    logic [31:0] exp1_dir[3];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tabla[0]  = mk(0, 0, 32'h0,  1, 32'h0,  32'h0,  0, 32'h0);
        tabla[1]  = mk(0, 0, 32'h0,  0, 32'h0,  32'h0,  0, 32'h0);
        tabla[2]  = mk(0, 0, 32'h0,  0, 32'h0,  32'h0,  0, 32'h0);
        tabla[3]  = mk(0, 0, 32'h0,  0, 32'h0,  32'h0,  1, 32'h0);
        tabla[4]  = mk(0, 1, 32'h0,  0, 32'h0,  32'h0,  1, 32'h0);
        tabla[5]  = mk(0, 1, 32'h0,  0, 32'h0,  32'h0,  1, 32'h0);
        tabla[6]  = mk(0, 1, 32'h0,  0, 32'h0,  32'h0,  1, 32'h0);
        tabla[7]  = mk(0, 0, 32'h0,  0, 32'h0,  32'h4,  0, 32'h0);
        tabla[8]  = mk(0, 0, 32'h0,  0, 32'h0,  32'h4,  0, 32'h0);
        tabla[9]  = mk(0, 0, 32'h0,  0, 32'h0,  32'h4,  0, 32'h0);
        tabla[10] = mk(1, 0, 32'h40, 1, 32'h40, 32'h40, 0, 32'h0);
        tabla[11] = mk(0, 0, 32'h0,  0, 32'h0,  32'h40, 0, 32'h0);
        tabla[12] = mk(0, 0, 32'h0,  0, 32'h0,  32'h40, 0, 32'h0);
        tabla[13] = mk(0, 0, 32'h0,  0, 32'h0,  32'h40, 0, 32'h0);
        tabla[14] = mk(0, 0, 32'h0,  0, 32'h0,  32'h40, 1, 32'h40);
        tabla[15] = mk(0, 0, 32'h0,  1, 32'h44, 32'h44, 0, 32'h0);
        tabla[16] = mk(0, 1, 32'h0,  0, 32'h0,  32'h44, 0, 32'h0);
        tabla[17] = mk(0, 1, 32'h0,  0, 32'h0,  32'h44, 0, 32'h0);
        tabla[18] = mk(0, 1, 32'h0,  0, 32'h0,  32'h44, 0, 32'h0);
        tabla[19] = mk(0, 1, 32'h0,  0, 32'h0,  32'h44, 1, 32'h44);
        tabla[20] = mk(0, 0, 32'h0,  0, 32'h0,  32'h48, 0, 32'h0);
        exp1_v[0] = 1'b1; exp1_dir[0] = 32'h0;
        exp1_v[1] = 1'b0; exp1_dir[1] = 32'h4;
        exp1_v[2] = 1'b1; exp1_dir[2] = 32'h4;

        reset = 1'b1; detener = 1'b0; salto = 1'b0; dir_salto = 32'h0;
        #2;
        chk("rst_dir_pc", dir_pc, 32'h0);
        chk("rst_valida", {31'h0, valida}, 32'h0);
        chk("rst_instruccion", instruccion, 32'h0);
        chk("rst_pc_inst", pc_inst, 32'h0);
`ifdef CHEQUEO_ALINEACION_EN
        chk("rst_error_alin", {31'h0, error_alin}, 32'h0);
`endif
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 21; i++) begin
            if (tabla[i].push) esperados.push_back(tabla[i].push_pc);
            paso(tabla[i].s, tabla[i].d, tabla[i].ds);
            chk($sformatf("row%0d_dir_pc", i + 1), dir_pc, tabla[i].e_dir);
            chk($sformatf("row%0d_valida", i + 1), {31'h0, valida}, {31'h0, tabla[i].e_v});
            if (tabla[i].e_v) begin
                chk($sformatf("row%0d_pc_inst", i + 1), pc_inst, tabla[i].e_pci);
                chk($sformatf("row%0d_instruccion", i + 1), instruccion, mem(tabla[i].e_pci));
            end
            if (i < 3) begin
                chk($sformatf("lat1_row%0d_valida", i + 1), {31'h0, valida1}, {31'h0, exp1_v[i]});
                chk($sformatf("lat1_row%0d_dir_pc", i + 1), dir_pc1, exp1_dir[i]);
                if (exp1_v[i]) chk($sformatf("lat1_row%0d_pc_inst", i + 1), pc_inst1, exp1_dir[i]);
            end
        end

        // Redirect to 8, then redirect again in the very cycle word 8 would be accepted.
        paso(1, 0, 32'h8);
        chk("salto8_dir_pc", dir_pc, 32'h8);
        for (int k = 0; k < 4; k++) paso(0, 1, 32'h0);
        chk("salto8_valida", {31'h0, valida}, 32'h1);
        chk("salto8_pc_inst", pc_inst, 32'h8);
        esperados.push_back(32'h100);
        paso(1, 0, 32'h100);
        chk("salto_accept_valida", {31'h0, valida}, 32'h0);
        chk("salto_accept_dir_pc", dir_pc, 32'h100);
        for (int k = 0; k < 3; k++) paso(0, 0, 32'h0);
        chk("salto_accept_early", {31'h0, valida}, 32'h0);
        paso(0, 0, 32'h0);
        chk("salto_accept_pc_inst", pc_inst, 32'h100);
        paso(0, 0, 32'h0);
        chk("after_100_dir_pc", dir_pc, 32'h104);

        // PC wrap past the top of the address space.
        esperados.push_back(32'hFFFF_FFFC);
        paso(1, 0, 32'hFFFF_FFFC);
        for (int k = 0; k < 4; k++) paso(0, 0, 32'h0);
        chk("wrap_pc_inst", pc_inst, 32'hFFFF_FFFC);
        paso(0, 0, 32'h0);
        chk("wrap_dir_pc", dir_pc, 32'h0);

`ifdef CHEQUEO_ALINEACION_EN
        paso(1, 0, 32'h46);
        chk("alin_dir_pc", dir_pc, 32'h44);
        chk("alin_error", {31'h0, error_alin}, 32'h1);
        for (int k = 0; k < 4; k++) paso(0, 1, 32'h0);
        chk("alin_pc_inst", pc_inst, 32'h44);
        paso(1, 0, 32'h80);
        chk("alin_sticky", {31'h0, error_alin}, 32'h1);
`endif

        // Held salto restarts the wait on every cycle.
        paso(1, 0, 32'h200);
        paso(1, 0, 32'h300);
        chk("multi_salto_dir_pc", dir_pc, 32'h300);
        for (int k = 0; k < 3; k++) paso(0, 1, 32'h0);
        chk("multi_salto_early", {31'h0, valida}, 32'h0);
        paso(0, 1, 32'h0);
        chk("multi_salto_pc_inst", pc_inst, 32'h300);

        // Asynchronous reset in the middle of a delivery.
        detener = 1'b1;
        #2 reset = 1'b1;
        #1;
        chk("async_rst_valida", {31'h0, valida}, 32'h0);
        chk("async_rst_dir_pc", dir_pc, 32'h0);
`ifdef CHEQUEO_ALINEACION_EN
        chk("async_rst_error", {31'h0, error_alin}, 32'h0);
`endif
        detener = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        esperados.push_back(32'h0);
        for (int k = 0; k < 3; k++) paso(0, 0, 32'h0);
        chk("post_rst_early", {31'h0, valida}, 32'h0);
        paso(0, 0, 32'h0);
        chk("post_rst_pc_inst", pc_inst, 32'h0);
        paso(0, 0, 32'h0);
        chk("post_rst_dir_pc", dir_pc, 32'h4);
        chk("sb_drained", esperados.size(), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
